// File: rtl/all_gates.sv
// Registered bank of the seven basic two-input gates plus an op_sel-routed result.
// Every output is a flop, and rst clears all of them immediately.
module all_gates #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_sel,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] nand_out,
    output logic [WIDTH-1:0] nor_out,
    output logic [WIDTH-1:0] xor_out,
    output logic [WIDTH-1:0] xnor_out,
    output logic [WIDTH-1:0] not_out,
    output logic [WIDTH-1:0] result_out,
    output logic             valid_out
);

    logic [WIDTH-1:0] and_next, or_next, nand_next, nor_next;
    logic [WIDTH-1:0] xor_next, xnor_next, not_next, result_next;
    logic [WIDTH-1:0] and_reg, or_reg, nand_reg, nor_reg;
    logic [WIDTH-1:0] xor_reg, xnor_reg, not_reg, result_reg;
    logic             valid_reg;

    // Each output bit sees only its own pair of operand bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign and_next[gi]  = a_in[gi] & b_in[gi];
        assign or_next[gi]   = a_in[gi] | b_in[gi];
        assign nand_next[gi] = ~(a_in[gi] & b_in[gi]);
        assign nor_next[gi]  = ~(a_in[gi] | b_in[gi]);
        assign xor_next[gi]  = a_in[gi] ^ b_in[gi];
        assign xnor_next[gi] = ~(a_in[gi] ^ b_in[gi]);
        assign not_next[gi]  = ~a_in[gi];
    end

    // The selection is taken from the same next-state vectors that load the
    // individual gate registers, so result_out always matches its gate.
    always_comb begin
        result_next = '0;
        case (op_sel)
            3'd0:    result_next = and_next;
            3'd1:    result_next = or_next;
            3'd2:    result_next = nand_next;
            3'd3:    result_next = nor_next;
            3'd4:    result_next = xor_next;
            3'd5:    result_next = xnor_next;
            3'd6:    result_next = not_next;
            default: result_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            and_reg    <= '0;
            or_reg     <= '0;
            nand_reg   <= '0;
            nor_reg    <= '0;
            xor_reg    <= '0;
            xnor_reg   <= '0;
            not_reg    <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= en;
            if (en) begin
                and_reg    <= and_next;
                or_reg     <= or_next;
                nand_reg   <= nand_next;
                nor_reg    <= nor_next;
                xor_reg    <= xor_next;
                xnor_reg   <= xnor_next;
                not_reg    <= not_next;
                result_reg <= result_next;
            end
        end
    end

    assign and_out    = and_reg;
    assign or_out     = or_reg;
    assign nand_out   = nand_reg;
    assign nor_out    = nor_reg;
    assign xor_out    = xor_reg;
    assign xnor_out   = xnor_reg;
    assign not_out    = not_reg;
    assign result_out = result_reg;
    assign valid_out  = valid_reg;

endmodule

// File: tb/tb_all_gates.sv
// Directed bench for all_gates: a 4-bit and a 1-bit instance share clk, rst and en.
module tb_all_gates;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [2:0] op4 = '0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [2:0] op1 = 3'd4;

    logic [3:0] and4, or4, nand4, nor4, xor4, xnor4, not4, res4;
    logic       valid4;
    logic       and1, or1, nand1, nor1, xor1, xnor1, not1, res1;
    logic       valid1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    all_gates #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .a_in(a4), .b_in(b4), .op_sel(op4),
        .and_out(and4), .or_out(or4), .nand_out(nand4), .nor_out(nor4),
        .xor_out(xor4), .xnor_out(xnor4), .not_out(not4), .result_out(res4),
        .valid_out(valid4)
    );

    all_gates #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .a_in(a1), .b_in(b1), .op_sel(op1),
        .and_out(and1), .or_out(or1), .nand_out(nand1), .nor_out(nor1),
        .xor_out(xor1), .xnor_out(xnor1), .not_out(not1), .result_out(res1),
        .valid_out(valid1)
    );

    // Packed views: {and, or, nand, nor, xor, xnor, not, result, valid}
    wire [32:0] all4 = {and4, or4, nand4, nor4, xor4, xnor4, not4, res4, valid4};
    wire [8:0]  all1 = {and1, or1, nand1, nor1, xor1, xnor1, not1, res1, valid1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (all4 !== 33'd0 || all1 !== 9'd0) begin
            errors++;
            $display("FAIL reset_immediate got4=%h got1=%h want 0", all4, all1);
        end
        en = 1'b1; a4 = 4'b1100; b4 = 4'b1010; a1 = 1'b1; b1 = 1'b0;
        tick();
        tick();
        checks++;
        if (all4 !== 33'd0 || all1 !== 9'd0) begin
            errors++;
            $display("FAIL reset_held got4=%h got1=%h want 0", all4, all1);
        end
        $display("reset: outputs 0 while rst=1 (%h %h)", all4, all1);
        en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_gates4();
        a4 = 4'b1100; b4 = 4'b1010; op4 = 3'd0; en = 1'b1;
        #1;
        checks++;
        if (all4 !== 33'd0) begin
            errors++;
            $display("FAIL no_comb_path got=%h want 0", all4);
        end
        tick();
        checks++;
        if (all4 !== {4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL gates4 got=%h want %h", all4,
                     {4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1000, 1'b1});
        end
        $display("gates4: a=1100 b=1010 -> %h", all4);
    endtask

    task automatic test_op_sel();
        logic [3:0] exp_res [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                                    4'b0110, 4'b1001, 4'b0011, 4'b0000};
        a4 = 4'b1100; b4 = 4'b1010; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op4 = 3'(i);
            tick();
            checks++;
            if (res4 !== exp_res[i] || valid4 !== 1'b1) begin
                errors++;
                $display("FAIL op_sel_%0d result=%b valid=%b want %b valid=1", i, res4, valid4, exp_res[i]);
            end
            $display("op_sel %0d: result=%b", i, res4);
        end
    endtask

    task automatic test_width1_sweep();
        // {and, or, nand, nor, xor, xnor, not, result(xor), valid}
        logic [8:0] exp1 [4] = '{9'b0_0_1_1_0_1_1_0_1, 9'b0_1_1_0_1_0_1_1_1,
                                 9'b0_1_1_0_1_0_0_1_1, 9'b1_1_0_0_0_1_0_0_1};
        en = 1'b1; op1 = 3'd4;
        for (int i = 0; i < 4; i++) begin
            a1 = i[1]; b1 = i[0];
            tick();
            checks++;
            if (all1 !== exp1[i]) begin
                errors++;
                $display("FAIL w1_sweep_ab%0d%0d got=%b want %b", i[1], i[0], all1, exp1[i]);
            end
            $display("w1 a=%0d b=%0d -> %b", i[1], i[0], all1);
        end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        a4 = 4'b1100; b4 = 4'b1010; op4 = 3'd2; en = 1'b1;
        tick();
        held = {4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b0111};
        en = 1'b0; a4 = 4'b0011; b4 = 4'b0101; op4 = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (all4 !== {held, 1'b0}) begin
                errors++;
                $display("FAIL hold_%0d got=%h want %h", i, all4, {held, 1'b0});
            end
            $display("hold cycle %0d: %h", i, all4);
        end
        // Back-to-back resume: new operands show up on the very next en=1 edge.
        en = 1'b1; op4 = 3'd4;
        tick();
        checks++;
        if (all4 !== {4'b0001, 4'b0111, 4'b1110, 4'b1000, 4'b0110, 4'b1001, 4'b1100, 4'b0110, 1'b1}) begin
            errors++;
            $display("FAIL resume got=%h want %h", all4,
                     {4'b0001, 4'b0111, 4'b1110, 4'b1000, 4'b0110, 4'b1001, 4'b1100, 4'b0110, 1'b1});
        end
        $display("resume: a=0011 b=0101 -> %h", all4);
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_xor;
        en = 1'b1; op4 = 3'd0;
        for (int c = 0; c < 20; c++) begin
            a4 = ((c / 3) % 2 == 0) ? 4'b1100 : 4'b0011;
            b4 = ((c / 7) % 2 == 0) ? 4'b1010 : 4'b0101;
            exp_xor = (((c / 3) % 2) == ((c / 7) % 2)) ? 4'b0110 : 4'b1001;
            tick();
            if (c % 5 == 4) begin
                checks++;
                if (xor4 !== exp_xor) begin
                    errors++;
                    $display("FAIL toggle_%0d xor=%b want %b", c, xor4, exp_xor);
                end
                $display("toggle cycle %0d: xor=%b", c, xor4);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all4 !== 33'd0 || all1 !== 9'd0) begin
            errors++;
            $display("FAIL async_reset got4=%h got1=%h want 0", all4, all1);
        end
        $display("async reset mid-cycle: %h %h", all4, all1);
        #1;
        rst = 1'b0;
        a4 = 4'b1100; b4 = 4'b1010; op4 = 3'd5; en = 1'b1;
        tick();
        checks++;
        if (all4 !== {4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1001, 1'b1}) begin
            errors++;
            $display("FAIL after_reset got=%h want %h", all4,
                     {4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1001, 1'b1});
        end
        $display("first edge after reset: %h", all4);
    endtask

    initial begin
        test_reset();
        test_gates4();
        test_op_sel();
        test_width1_sweep();
        test_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/all_gates.md
ALL_GATES -- requirements
Module: all_gates

Interface
REQ-001: Parameter WIDTH, default 1, SHALL set the bit width of both operands and of every gate output (legal range 1..64).
REQ-002: clk  input  1  SHALL be the single clock; all outputs SHALL update only on its rising edge.
REQ-003: rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004: en  input  1  SHALL be the sample enable; operands are captured only when en=1.
REQ-005: a_in  input  WIDTH  SHALL be operand A.
REQ-006: b_in  input  WIDTH  SHALL be operand B.
REQ-007: op_sel  input  3  SHALL select the gate routed to result_out.
REQ-008: and_out, or_out, nand_out, nor_out, xor_out, xnor_out  output  WIDTH each  SHALL be the registered bitwise A&B, A|B, ~(A&B), ~(A|B), A^B, ~(A^B).
REQ-009: not_out  output  WIDTH  SHALL be the registered bitwise ~A; b_in SHALL NOT affect it.
REQ-010: result_out  output  WIDTH  SHALL be the registered gate result chosen by op_sel.
REQ-011: valid_out  output  1  SHALL mark that the outputs hold a result computed from a sample taken on the previous edge.

Function
REQ-012: All gate outputs SHALL be bitwise: bit i depends only on a_in[i] and b_in[i].
REQ-013: Latency SHALL be exactly 1 cycle: operands sampled at edge N with en=1 SHALL appear on all outputs after edge N.
REQ-014: With en=0 at an edge, all gate outputs and result_out SHALL hold their previous values.
REQ-015: valid_out SHALL be 1 after an edge with en=1 and 0 after an edge with en=0.
REQ-016: op_sel mapping SHALL be 0=AND, 1=OR, 2=NAND, 3=NOR, 4=XOR, 5=XNOR, 6=NOT A, 7=all zeros.
REQ-017: op_sel SHALL be sampled on the same edge and under the same en condition as the operands.
REQ-018: At every edge, result_out SHALL be identical to the selected individual gate output (or zero for 7).
REQ-019: Outputs SHALL remain stable between clock edges, with no combinational path from inputs to outputs.
REQ-020: X/Z on inputs is out of scope; no X handling logic SHALL be added.

Reset
REQ-021: While rst=1, every output SHALL be 0 immediately, regardless of clk. This includes nand_out, nor_out, xnor_out and not_out, which are forced to 0 and not to their logical value for zero operands.
REQ-022: rst asserted mid-operation SHALL clear all outputs within the same cycle, and valid_out SHALL be 0.
REQ-023: After rst deasserts, the first edge with en=1 SHALL produce valid results, with no extra warm-up cycle.

Verification
REQ-024: WIDTH=1, en=1, sweep (a,b)=00,01,10,11 on successive edges -> after each edge and/or/nand/nor/xor/xnor = 0/0/1/1/0/1, 0/1/1/0/1/0, 0/1/1/0/1/0, 1/1/0/0/0/1; not_out = 1,1,0,0; valid_out=1.
REQ-025: WIDTH=4, a=1100, b=1010, en=1 -> and 1000, or 1110, nand 0111, nor 0001, xor 0110, xnor 1001, not 0011, one cycle later.
REQ-026: WIDTH=4, a=1100, b=1010, op_sel stepped 0..7 with en=1 -> result_out = 1000, 1110, 0111, 0001, 0110, 1001, 0011, 0000 on consecutive cycles.
REQ-027: Load a=1100, b=1010, then en=0 with a=0011, b=0101 for 3 cycles -> outputs hold the first results, and valid_out=0 from the first en=0 edge.
REQ-028: Free-running toggles (a_in period 6 cycles, b_in period 14 cycles), then rst=1 pulsed between edges -> all outputs 0 asynchronously. After release, the first en=1 edge gives correct results.
